// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Unsigned sizes exist only for loads; everything else must be naturally aligned.
    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic err;
        case (f3)
            F3_B:         err = 1'b0;
            F3_H:         err = off[0];
            F3_W:         err = (off != 2'b00);
            F3_BU:        err = we;
            F3_HU:        err = we | off[0];
            default:      err = 1'b1;
        endcase
        return err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_if
// Description : Request/grant/read-valid data-memory bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Byte-enable / write-lane generation and load-lane extraction.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [31:0] w_lane;

    assign w_lane = rdata_i >> {off_i, 3'b000};

    always_comb begin
        case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{w_lane[7] & ~uns_i}}, w_lane[7:0]};
            end
            SZ_H: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{w_lane[15] & ~uns_i}}, w_lane[15:0]};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store bus initiator with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    lsu_mem_if.master   mem
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               w_accept;
    logic               w_req_err;
    logic               w_timeout;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_ext;
    logic               w_unused;

    assign w_unused  = ^req_addr_i[31:ADDR_W+2];
    assign w_accept  = (state_q == ST_IDLE) && req_valid_i;
    assign w_req_err = access_err(req_we_i, req_funct3_i, req_addr_i[1:0]);
    // Fires in the TIMEOUT-th cycle spent in REQ or WAIT.
    assign w_timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

    lsu_align u_align (
        .size_i  (f3_q[1:0]),
        .uns_i   (f3_q[2]),
        .off_i   (addr_q[1:0]),
        .wdata_i (wdata_q),
        .rdata_i (mem.rdata),
        .be_o    (w_be),
        .wdata_o (w_wdata),
        .rdata_o (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Grant / read-valid take priority over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid_i) state_d = w_req_err ? ST_RESP : ST_REQ;
            ST_REQ: begin
                if (mem.gnt)        state_d = we_q ? ST_RESP : ST_WAIT;
                else if (w_timeout) state_d = ST_RESP;
            end
            ST_WAIT: if (mem.rvalid || w_timeout) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == ST_IDLE);
        rsp_valid_o = (state_q == ST_RESP);
        rsp_err_o   = (state_q == ST_RESP) && err_q;
        rsp_rdata_o = (state_q == ST_RESP) ? rdata_q : 32'd0;
        mem.req     = (state_q == ST_REQ);
        mem.we      = (state_q == ST_REQ) && we_q;
        mem.addr    = (state_q == ST_REQ) ? addr_q[ADDR_W+1:2] : '0;
        mem.be      = (state_q == ST_REQ) ? w_be : 4'd0;
        mem.wdata   = (state_q == ST_REQ) ? w_wdata : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (w_accept) begin
                we_q    <= req_we_i;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i[ADDR_W+1:0];
                wdata_q <= req_wdata_i;
                rdata_q <= 32'd0;
                err_q   <= w_req_err;
            end
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == ST_REQ || state_q == ST_WAIT)
                cnt_q <= cnt_q + 1'b1;
            if (state_q == ST_REQ && !mem.gnt && w_timeout)
                err_q <= 1'b1;
            if (state_q == ST_WAIT) begin
                if (mem.rvalid)     rdata_q <= w_ext;
                else if (w_timeout) err_q   <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench: directed vectors, timeout/reset corners,
//               and random traffic against a byte-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    lsu_mem_if #(.ADDR_W(ADDR_W)) mem_bus ();

    load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .mem          (mem_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] dev_mem [1024];
    logic [7:0]  ref_mem [4096];

    typedef struct {
        int          req_first, req_cnt, gnt_cyc, rsp_cyc;
        logic        err, mwe, req_at_rsp, ready_after;
        logic [31:0] rdata, mwd;
        logic [3:0]  be;
        logic [9:0]  maddr;
        bit          stable, ready_ok;
    } txn_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, word;
        logic        err;
        logic [3:0]  be;
        logic [31:0] mwd, rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte-addressed memory) ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        bit legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 1'b1;
        return (a % sz) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be = 4'd0;
        for (int i = 0; i < size_of(f3); i++) be[(a + i) % 4] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (size_of(f3))
            1:       return {24'd0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'd0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < sz; i++) v = v | ({24'd0, ref_mem[(a[11:0] + i) % 4096]} << (8 * i));
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < size_of(f3); i++) ref_mem[(a[11:0] + i) % 4096] = wd[8 * i +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] word);
        dev_mem[a[11:2]] = word;
        for (int b = 0; b < 4; b++) ref_mem[{a[11:2], 2'b00} + b] = word[8 * b +: 8];
    endtask

    // ---------------- one transaction with a delay-programmable memory ----------------
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                           output txn_t r);
        int  c = 0, seen = 0, rv_at = -1;
        bit  done = 0, granted = 0;
        r = '{req_first: -1, gnt_cyc: -1, rsp_cyc: -1, stable: 1, ready_ok: 1, default: 0};
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        while (!done && c < 60) begin
            @(posedge clk); #1; c++;
            req_valid = 1'b0; mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0;
            mem_bus.rdata = $urandom;
            if (req_ready) r.ready_ok = 0;
            if (rsp_valid) begin
                r.rsp_cyc = c; r.err = rsp_err; r.rdata = rsp_rdata;
                r.req_at_rsp = mem_bus.req; done = 1;
            end
            if (mem_bus.req) begin
                if (r.req_first < 0) begin
                    r.req_first = c; r.be = mem_bus.be; r.mwd = mem_bus.wdata;
                    r.maddr = mem_bus.addr; r.mwe = mem_bus.we;
                end else if (r.be !== mem_bus.be || r.mwd !== mem_bus.wdata ||
                             r.maddr !== mem_bus.addr || r.mwe !== mem_bus.we) begin
                    r.stable = 0;
                end
                r.req_cnt++;
                if (!granted && seen == gnt_dly) begin
                    granted = 1; mem_bus.gnt = 1'b1; r.gnt_cyc = c;
                    if (mem_bus.we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_bus.be[b]) dev_mem[mem_bus.addr][8 * b +: 8] = mem_bus.wdata[8 * b +: 8];
                    end else begin
                        rv_at = c + 1 + rv_dly;
                    end
                end
                seen++;
            end
            if (c == rv_at) begin
                mem_bus.rvalid = 1'b1;
                mem_bus.rdata  = dev_mem[r.maddr];
            end
        end
        if (done) begin
            @(posedge clk); #1;
            r.ready_after = req_ready;
        end
    endtask

    task automatic late_rvalid_ignored(input string name);
        int bad = 0;
        mem_bus.rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            mem_bus.rvalid = 1'b0;
            if (rsp_valid) bad++;
        end
        check(name, bad, 0);
    endtask

    vec_t tbl [14];
    txn_t r;

    initial begin
        for (int i = 0; i < 1024; i++) dev_mem[i] = 32'd0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", req_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_err",   rsp_err, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset mem_req",   mem_bus.req, 0);
        check("reset mem_be",    mem_bus.be, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //              we  f3     addr         wdata        word         err   be       mwd          rdata
        tbl[0]  = '{1'b1, F3_W,  32'h70, 32'hDEAD_BEEF, 32'h0,        1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        tbl[1]  = '{1'b0, F3_B,  32'h71, 32'h0,         32'h0000_8000, 1'b0, 4'b0010, 32'h0,        32'hFFFF_FF80};
        tbl[2]  = '{1'b0, F3_BU, 32'h71, 32'h0,         32'h0000_8000, 1'b0, 4'b0010, 32'h0,        32'h0000_0080};
        tbl[3]  = '{1'b1, F3_H,  32'h72, 32'h0000_1234, 32'h0,        1'b0, 4'b1100, 32'h1234_1234, 32'h0};
        tbl[4]  = '{1'b0, F3_W,  32'h06, 32'h0,         32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, F3_H,  32'h42, 32'h0,         32'h8001_7FFF, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001};
        tbl[6]  = '{1'b0, F3_HU, 32'h42, 32'h0,         32'h8001_7FFF, 1'b0, 4'b1100, 32'h0,        32'h0000_8001};
        tbl[7]  = '{1'b0, F3_W,  32'h44, 32'h0,         32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0,        32'hCAFE_F00D};
        tbl[8]  = '{1'b1, F3_B,  32'h13, 32'h0000_00AB, 32'h0,        1'b0, 4'b1000, 32'hABAB_ABAB, 32'h0};
        tbl[9]  = '{1'b1, F3_H,  32'h01, 32'h0000_5555, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[10] = '{1'b1, F3_BU, 32'h20, 32'h0000_0011, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[11] = '{1'b0, 3'b011, 32'h20, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[12] = '{1'b0, F3_B,  32'h0C, 32'h0,         32'h0000_007F, 1'b0, 4'b0001, 32'h0,        32'h0000_007F};
        tbl[13] = '{1'b0, F3_H,  32'h03, 32'h0,         32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};

        for (int i = 0; i < 14; i++) begin
            if (!tbl[i].we && !tbl[i].err) preload(tbl[i].addr, tbl[i].word);
            check("vec ready at accept", req_ready, 1);
            run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 0, 0, r);
            check("vec rsp_err",   r.err, tbl[i].err);
            check("vec rsp_rdata", r.rdata, tbl[i].rdata);
            check("vec rsp cycle", r.rsp_cyc, tbl[i].err ? 1 : (tbl[i].we ? 2 : 3));
            check("vec ready low", r.ready_ok, 1);
            check("vec ready after rsp", r.ready_after, 1);
            if (tbl[i].err) begin
                check("vec err no mem_req", r.req_cnt, 0);
            end else begin
                check("vec mem_req at N+1", r.req_first, 1);
                check("vec mem_be",   r.be, tbl[i].be);
                check("vec mem_addr", r.maddr, tbl[i].addr[11:2]);
                check("vec mem_we",   r.mwe, tbl[i].we);
                if (tbl[i].we) begin
                    check("vec mem_wdata", r.mwd, tbl[i].mwd);
                    ref_store(tbl[i].f3, tbl[i].addr, tbl[i].wdata);
                end
            end
        end

        // No grant at all: err after TIMEOUT request cycles, request dropped.
        run_txn(1'b1, F3_W, 32'h80, 32'h1111_2222, NEVER, 0, r);
        check("nogrant err",      r.err, 1);
        check("nogrant rsp cycle", r.rsp_cyc, TIMEOUT + 1);
        check("nogrant req cycles", r.req_cnt, TIMEOUT);
        check("nogrant req dropped", r.req_at_rsp, 0);
        check("nogrant stable",   r.stable, 1);
        late_rvalid_ignored("nogrant late rvalid");

        // Granted load whose data never returns.
        run_txn(1'b0, F3_W, 32'h84, 32'h0, 0, NEVER, r);
        check("norv err",       r.err, 1);
        check("norv rdata",     r.rdata, 0);
        check("norv rsp cycle", r.rsp_cyc, TIMEOUT + 2);
        late_rvalid_ignored("norv late rvalid");

        // Grant / rvalid in the final allowed cycle still win.
        run_txn(1'b1, F3_H, 32'h8A, 32'h0000_BEEF, TIMEOUT - 1, 0, r);
        check("lastgnt err",       r.err, 0);
        check("lastgnt rsp cycle", r.rsp_cyc, TIMEOUT + 1);
        ref_store(F3_H, 32'h8A, 32'h0000_BEEF);
        run_txn(1'b0, F3_HU, 32'h8A, 32'h0, 0, TIMEOUT - 1, r);
        check("lastrv err",       r.err, 0);
        check("lastrv rdata",     r.rdata, 32'h0000_BEEF);
        check("lastrv rsp cycle", r.rsp_cyc, TIMEOUT + 2);

        // Reset while waiting for read data.
        begin
            int bad = 0;
            req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h100;
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("rst-mid mem_req", mem_bus.req, 1);
            mem_bus.gnt = 1'b1;
            @(posedge clk); #1;
            mem_bus.gnt = 1'b0;
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1;
            check("rst-mid req_ready", req_ready, 1);
            check("rst-mid mem_req",   mem_bus.req, 0);
            check("rst-mid rsp_valid", rsp_valid, 0);
            check("rst-mid rsp_rdata", rsp_rdata, 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h1234_5678;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                mem_bus.rvalid = 1'b0;
                if (rsp_valid || !req_ready) bad++;
            end
            check("rst-mid no response", bad, 0);
        end

        // Random traffic against the byte-level model.
        for (int n = 0; n < 150; n++) begin
            logic        we   = 1'($urandom_range(0, 1));
            logic [2:0]  f3   = 3'($urandom_range(0, 7));
            logic [31:0] a    = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            logic [31:0] wd   = $urandom;
            int          gd   = $urandom_range(0, 3);
            int          rd   = $urandom_range(0, 3);
            logic        eerr = ref_err(we, f3, a);
            logic [31:0] erd  = (we || eerr) ? 32'd0 : ref_load(f3, a);
            run_txn(we, f3, a, wd, gd, rd, r);
            check("rnd err", r.err, eerr);
            check("rnd rdata", r.rdata, erd);
            check("rnd rsp cycle", r.rsp_cyc, eerr ? 1 : (we ? gd + 2 : gd + rd + 3));
            check("rnd ready after rsp", r.ready_after, 1);
            if (eerr) begin
                check("rnd err no mem_req", r.req_cnt, 0);
            end else begin
                check("rnd mem_be", r.be, ref_be(f3, a));
                check("rnd mem_addr", r.maddr, a[11:2]);
                check("rnd stable", r.stable, 1);
                if (we) begin
                    check("rnd mem_wdata", r.mwd, ref_wdata(f3, wd));
                    ref_store(f3, a, wd);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Bus initiator that connects the CPU datapath to the data memory. It accepts one load or store per transaction from the execute stage. It generates word-addressed memory requests with byte enables, and for loads it extracts and sign/zero-extends the returned lane. It runs a request/grant/read-valid handshake toward memory, reports misaligned or illegal accesses, and aborts transactions when the memory stops responding.

## Interface
- `ADDR_W`, 10: memory word-address width (1024 words)
- `TIMEOUT`, 15: maximum cycles to wait for `mem_gnt` or `mem_rvalid` before aborting
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; **asynchronous, active-low**
- `req_valid`  in  1  core request present
- `req_ready`  out  1  unit is in IDLE and can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors
- `rsp_err`  out  1  misaligned, illegal funct3, or timeout; valid with `rsp_valid`
- `mem_req`  out  1  memory request
- `mem_we`  out  1  write enable
- `mem_addr`  out  ADDR_W  word index, equal to `req_addr[ADDR_W+1:2]`
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-replicated write data
- `mem_gnt`  in  1  memory accepts the request
- `mem_rvalid`  in  1  read data valid; asserted no earlier than the cycle after `mem_gnt`
- `mem_rdata`  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch all `req_*` inputs.
  - Misaligned access (H with `addr[0]`=1, or W with `addr[1:0]`≠0), or funct3 not in {000, 001, 010} for stores or {000, 001, 010, 100, 101} for loads: go to RESP with err=1. No memory access is made.
  - Otherwise go to REQ.
- **REQ**
  - `mem_req`=1; `mem_we`, `mem_addr`, `mem_be`, and `mem_wdata` are registered and held stable until grant.
  - On `mem_gnt`: a store goes to RESP; a load goes to WAIT.
- **WAIT**
  - On `mem_rvalid`, latch the extracted lane into `rsp_rdata` and go to RESP.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle, then go to IDLE.
  - The response has no backpressure.
- **Byte enables:** B gives `4'b0001 << addr[1:0]`. H gives `4'b0011 << addr[1:0]`. W gives `4'b1111`.
- **Write data:** B replicates `wdata[7:0]` ×4. H replicates `wdata[15:0]` ×2.
- **Load extract:** select the byte or halfword at `addr[1:0]`. B/H sign-extend from the top bit of the lane; BU/HU zero-extend.
- **Timeout:** a counter clears on entry to REQ and to WAIT and increments each cycle in those states. Reaching TIMEOUT goes to RESP with err=1, drops `mem_req`, and ignores any later `mem_rvalid`.
- **Reset:** asynchronous return to IDLE from any state. All outputs 0 except `req_ready`=1. An in-flight transaction is discarded with no response.

## Timing
- Accept happens in cycle N. `mem_req` rises in N+1.
- **Store:** grant in cycle G gives `rsp_valid` in G+1. Best case `rsp_valid` at N+2.
- **Load:** `mem_rvalid` in cycle R gives `rsp_valid` and `rsp_rdata` in R+1. Best case at N+3 (gnt at N+1, rvalid at N+2).
- **Error:** `rsp_valid` at N+1 with `mem_req` never asserted.
- `req_ready` is 0 from N+1 until the cycle after the `rsp_valid` pulse, so back-to-back throughput is one transaction per 3 cycles for a zero-wait store.
- `mem_gnt` in the same cycle that the counter reaches TIMEOUT: the grant wins.

## Structure
- **`lsu_pkg`:** funct3 encodings (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the state enum.
- **`lsu_align`:** combinational sub-module. It computes `mem_be` and `mem_wdata` from size, offset, and data, and computes load extraction from `mem_rdata`, size, sign, and offset.
- **Top level:** FSM, request registers, and timeout counter.

## Test plan
- **SW with zero-wait memory:** addr 0x70, wdata 0xDEADBEEF, gnt at N+1. Expect `mem_addr`=28, `mem_be`=1111, `rsp_valid` at N+2 with err=0.
- **LB with sign extension:** addr 0x71, memory word 0x0000_8000. Expect `mem_be`=0010 and `rsp_rdata`=0xFFFF_FF80. LBU at the same address returns 0x0000_0080.
- **SH with upper lane:** addr 0x72, wdata 0x1234. Expect `mem_be`=1100 and `mem_wdata`=0x1234_1234.
- **Misaligned LW:** addr 0x06. Expect `rsp_err`=1 at N+1, `mem_req` never 1, and `req_ready` back to 1 at N+2.
- **No grant:** hold gnt low. Expect err response after TIMEOUT cycles in REQ and `mem_req` dropped. Check that a late `mem_rvalid` is ignored.
- **Reset mid-transaction:** assert `rst`=0 while in WAIT. Expect an immediate return to IDLE with outputs at reset values and no `rsp_valid`.
